ring_meas_scheduler: RTL and testbench

//  Sequences ring-oscillator frequency measurements over N_RINGS selectable rings.

---
 rtl/ring_meas_scheduler_if.sv | 27 ++
 rtl/ring_meas_scheduler.sv | 154 +++++++++++++++
 tb/tb_ring_meas_scheduler.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ring_meas_scheduler_if.sv
// Result port of the ring measurement scheduler: one 16-bit count per ring,
// tagged with its ring index, on a valid/ready handshake.
`timescale 1ns/1ps
interface ring_meas_scheduler_if #(
    parameter int N_RINGS = 8
);
    localparam int SEL_W = $clog2(N_RINGS);

    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic [SEL_W-1:0] res_ring;

    modport master (
        output res_valid,
        output res_data,
        output res_ring,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_ring,
        output res_ready
    );
endinterface

// File: rtl/ring_meas_scheduler.sv
// Sweeps ring oscillators through clear/gate/settle/capture windows, one result per ring.
// Define MEAS_AVG_EN to average 2**AVG_LOG2 windows per ring (AVG_LOG2 exists only then).
`timescale 1ns/1ps
module ring_meas_scheduler #(
`ifdef MEAS_AVG_EN
    parameter int AVG_LOG2   = 2,
`endif
    parameter int N_RINGS    = 8,
    parameter int GATE_CYC   = 100,
    parameter int CLR_CYC    = 2,
    parameter int SETTLE_CYC = 4,
    localparam int SEL_W     = $clog2(N_RINGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [N_RINGS-1:0]   ring_mask,
    output logic [SEL_W-1:0]     ring_sel,
    output logic                 cnt_clr,
    output logic                 cnt_en,
    input  logic [15:0]          cnt_value,
    ring_meas_scheduler_if.master res,
    output logic                 busy,
    output logic                 err_empty
);
    localparam int MAX_CYC = (GATE_CYC > CLR_CYC) ?
                             ((GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC) :
                             ((CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC);
    localparam int TMR_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, GATE, SETTLE, CAPTURE, OUTPUT
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q;
    logic [N_RINGS-1:0] mask_q;
    logic [15:0]        res_data_q;
    logic [SEL_W-1:0]   res_ring_q;
    logic [SEL_W-1:0]   next_ring, first_ring;
    logic               has_next, mask_empty, last_win;
    logic               start_ok, hop, sweep_end, restart;

`ifdef MEAS_AVG_EN
    localparam int ACC_W = 16 + AVG_LOG2;
    localparam int WIN_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [ACC_W-1:0] acc_q, acc_sum;
    logic [WIN_W-1:0] win_q;

    assign acc_sum  = acc_q + ACC_W'(cnt_value);
    assign last_win = (win_q == WIN_W'((1 << AVG_LOG2) - 1));
`else
    assign last_win = 1'b1;
`endif

    // Smallest set bit of mask_q above the current ring, and lowest bit of the live mask
    always_comb begin
        has_next   = 1'b0;
        next_ring  = '0;
        first_ring = '0;
        for (int i = N_RINGS - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ring_sel))) begin
                has_next  = 1'b1;
                next_ring = SEL_W'(i);
            end
            if (ring_mask[i]) begin
                first_ring = SEL_W'(i);
            end
        end
    end

    assign mask_empty = (ring_mask == '0);
    assign start_ok   = (state_q == IDLE) && start && !mask_empty;
    assign hop        = (state_q == OUTPUT) && res.res_ready && has_next;
    assign sweep_end  = (state_q == OUTPUT) && res.res_ready && !has_next;
    assign restart    = sweep_end && continuous && !mask_empty;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = CLEAR;
            CLEAR:   if (timer_q == TMR_W'(CLR_CYC - 1)) state_d = GATE;
            GATE:    if (timer_q == TMR_W'(GATE_CYC - 1)) state_d = SETTLE;
            SETTLE:  if (timer_q == TMR_W'(SETTLE_CYC - 1)) state_d = CAPTURE;
            CAPTURE: state_d = last_win ? OUTPUT : CLEAR;
            OUTPUT: begin
                if (hop || restart) state_d = CLEAR;
                else if (sweep_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            mask_q     <= '0;
            ring_sel   <= '0;
            res_data_q <= '0;
            res_ring_q <= '0;
            err_empty  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (state_q inside {CLEAR, GATE, SETTLE}) begin
                timer_q <= timer_q + 1'b1;
            end
            err_empty <= ((state_q == IDLE) && start && mask_empty) ||
                         (sweep_end && continuous && mask_empty);
            // The live mask is only looked at on sweep boundaries
            if (start_ok || restart) begin
                mask_q   <= ring_mask;
                ring_sel <= first_ring;
            end else if (hop) begin
                ring_sel <= next_ring;
            end
            if ((state_q == CAPTURE) && last_win) begin
`ifdef MEAS_AVG_EN
                res_data_q <= acc_sum[AVG_LOG2 +: 16];
`else
                res_data_q <= cnt_value;
`endif
                res_ring_q <= ring_sel;
            end
        end
    end

`ifdef MEAS_AVG_EN
    // Accumulator restarts whenever a new ring begins its first window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            win_q <= '0;
        end else if (start_ok || restart || hop) begin
            acc_q <= '0;
            win_q <= '0;
        end else if ((state_q == CAPTURE) && !last_win) begin
            acc_q <= acc_sum;
            win_q <= win_q + 1'b1;
        end
    end
`endif

    assign cnt_clr       = (state_q == IDLE) || (state_q == CLEAR);
    assign cnt_en        = (state_q == GATE);
    assign busy          = (state_q != IDLE);
    assign res.res_valid = (state_q == OUTPUT);
    assign res.res_data  = res_data_q;
    assign res.res_ring  = res_ring_q;
endmodule

// File: tb/tb_ring_meas_scheduler.sv
// Directed bench for ring_meas_scheduler: counter model plus a result scoreboard.
`timescale 1ns/1ps
module tb_ring_meas_scheduler;
    localparam int N_RINGS    = 8;
    localparam int GATE_CYC   = 100;
    localparam int CLR_CYC    = 2;
    localparam int SETTLE_CYC = 4;
    localparam int SEL_W      = $clog2(N_RINGS);
`ifdef MEAS_AVG_EN
    localparam int AVG_LOG2   = 2;
    localparam int WINDOWS    = 1 << AVG_LOG2;
`else
    localparam int WINDOWS    = 1;
`endif
    localparam int RING_LAT   = (CLR_CYC + GATE_CYC + SETTLE_CYC + 1) * WINDOWS;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               continuous;
    logic [N_RINGS-1:0] ring_mask;
    logic [SEL_W-1:0]   ring_sel;
    logic               cnt_clr;
    logic               cnt_en;
    logic [15:0]        cnt_value;
    logic               busy;
    logic               err_empty;

    logic [15:0] cnt_raw    = '0;
    logic        cnt_en_d   = 1'b0;
    int          gates_seen = 0;
    int          gate_base  = 0;
    logic        avg_mode   = 1'b0;

    typedef struct packed {
        logic [SEL_W-1:0] ring;
        logic [15:0]      data;
    } result_t;

    result_t sb_q[$];
    int      checks = 0;
    int      errors = 0;
    int      pops   = 0;

    ring_meas_scheduler_if #(.N_RINGS(N_RINGS)) rif ();

    ring_meas_scheduler #(
`ifdef MEAS_AVG_EN
        .AVG_LOG2   (AVG_LOG2),
`endif
        .N_RINGS    (N_RINGS),
        .GATE_CYC   (GATE_CYC),
        .CLR_CYC    (CLR_CYC),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .ring_mask  (ring_mask),
        .ring_sel   (ring_sel),
        .cnt_clr    (cnt_clr),
        .cnt_en     (cnt_en),
        .cnt_value  (cnt_value),
        .res        (rif),
        .busy       (busy),
        .err_empty  (err_empty)
    );

    always #5 clk = ~clk;

    // Counter model: one count per gated clock; avg_mode adds the window index
    always @(posedge clk) begin
        cnt_en_d <= cnt_en;
        if (cnt_en && !cnt_en_d) gates_seen <= gates_seen + 1;
        if (cnt_clr) cnt_raw <= '0;
        else if (cnt_en) cnt_raw <= cnt_raw + 16'd1;
    end
    assign cnt_value = cnt_raw + (avg_mode ? 16'(gates_seen - gate_base - 1) : 16'd0);

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic expectResult(input logic [SEL_W-1:0] ring, input logic [15:0] data);
        result_t e;
        e.ring = ring;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [N_RINGS-1:0] mask, input logic cont);
        ring_mask  = mask;
        continuous = cont;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (!rif.res_valid && n < 5000) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy && n < 20000) begin
            @(posedge clk);
            #1 n++;
        end
        checkOutput(tag, busy, 1'b0);
    endtask

    task automatic waitPops(input string tag, input int target);
        int n = 0;
        while (pops < target && n < 20000) begin
            @(posedge clk);
            #1 n++;
        end
        checkOutput(tag, pops, target);
    endtask

    // Scoreboard: every handshake must match the oldest expected result
    always @(negedge clk) begin
        result_t e;
        if (rif.res_valid && rif.res_ready) begin
            checkOutput("result_expected", sb_q.size() > 0, 1'b1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("res_ring", rif.res_ring, e.ring);
                checkOutput("res_data", rif.res_data, e.data);
            end
            pops++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   n, p0;
        logic hold_ok, quiet_ok;
        logic [15:0]      held_data;
        logic [SEL_W-1:0] held_ring;

        rst           = 1'b1;
        start         = 1'b0;
        continuous    = 1'b0;
        ring_mask     = '0;
        rif.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_cnt_clr", cnt_clr, 1'b1);
        checkOutput("rst_cnt_en", cnt_en, 1'b0);
        checkOutput("rst_res_valid", rif.res_valid, 1'b0);
        checkOutput("rst_err_empty", err_empty, 1'b0);
        checkOutput("rst_ring_sel", ring_sel, 0);
        checkOutput("rst_res_data", rif.res_data, 0);
        checkOutput("rst_res_ring", rif.res_ring, 0);
        rst = 1'b0;

        $display("[TB] two-ring sweep");
        rif.res_ready = 1'b1;
        p0 = pops;
        expectResult(0, 16'd100);
        expectResult(2, 16'd100);
        applyStimulus(8'h05, 1'b0);
        checkOutput("t1_busy", busy, 1'b1);
        checkOutput("t1_clear", cnt_clr, 1'b1);
        waitValid(n);
        checkOutput("t1_latency", n, RING_LAT);
        waitIdle("t1_idle");
        checkOutput("t1_results", pops - p0, 2);

        $display("[TB] empty mask");
        applyStimulus(8'h00, 1'b0);
        checkOutput("t2_err_pulse", err_empty, 1'b1);
        checkOutput("t2_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("t2_err_single", err_empty, 1'b0);
        checkOutput("t2_busy_after", busy, 1'b0);
        checkOutput("t2_no_valid", rif.res_valid, 1'b0);

        $display("[TB] backpressure");
        rif.res_ready = 1'b0;
        p0 = pops;
        expectResult(1, 16'd100);
        applyStimulus(8'h02, 1'b0);
        waitValid(n);
        checkOutput("t3_valid", rif.res_valid, 1'b1);
        held_data = rif.res_data;
        held_ring = rif.res_ring;
        hold_ok   = 1'b1;
        quiet_ok  = 1'b1;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (!rif.res_valid || rif.res_data !== held_data || rif.res_ring !== held_ring)
                hold_ok = 1'b0;
            if (cnt_en || cnt_clr) quiet_ok = 1'b0;
        end
        checkOutput("t3_hold", hold_ok, 1'b1);
        checkOutput("t3_no_clear", quiet_ok, 1'b1);
        rif.res_ready = 1'b1;
        waitIdle("t3_idle");
        checkOutput("t3_results", pops - p0, 1);

        $display("[TB] continuous with mask change");
        p0 = pops;
        expectResult(7, 16'd100);
        expectResult(7, 16'd100);
        expectResult(0, 16'd100);
        applyStimulus(8'h80, 1'b1);
        waitPops("t4_first", p0 + 1);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("t4_mid_gate", cnt_en, 1'b1);
        checkOutput("t4_ring7", ring_sel, 7);
        ring_mask = 8'h01;
        waitPops("t4_second", p0 + 2);
        checkOutput("t4_ring0", ring_sel, 0);
        continuous = 1'b0;
        waitIdle("t4_idle");
        checkOutput("t4_results", pops - p0, 3);

        $display("[TB] reset mid-gate");
        applyStimulus(8'h01, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        checkOutput("t5_in_gate", cnt_en, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("t5_cnt_en", cnt_en, 1'b0);
        checkOutput("t5_cnt_clr", cnt_clr, 1'b1);
        checkOutput("t5_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        p0 = pops;
        expectResult(0, 16'd100);
        applyStimulus(8'h01, 1'b0);
        waitIdle("t5_idle");
        checkOutput("t5_results", pops - p0, 1);

`ifdef MEAS_AVG_EN
        $display("[TB] averaging");
        avg_mode  = 1'b1;
        gate_base = gates_seen;
        expectResult(0, 16'd101);
        applyStimulus(8'h01, 1'b0);
        waitIdle("t6_idle");
        checkOutput("t6_gates", gates_seen - gate_base, 4);
        avg_mode = 1'b0;
`endif

        checkOutput("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
